reg_file_ctrl: RTL and testbench
================================

// Module: reg_file_ctrl
// PURPOSE
//   Command sequencer that sits directly upstream of the 8 x 16 register file.
//   - Accepts read/write commands on a valid/ready interface.
//   - Drives the register file's WrEn/RdEn/Address/WrData pins.
//   - Captures RdData after the file's read latency.
//   - Returns read data on a valid/ready response interface.
//   Lets bus masters access the file without knowing its pin-level timing.
// PARAMETERS
//   WIDTH   16  data width; matches the register file word
//   DEPTH    8  number of register-file entries
//   ADDR     3  address width, = log2(DEPTH)
//   RD_LAT   1  cycles from the RdEn-high cycle to RdData valid; legal range 1..4
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      controller can accept a command
//   cmd_wr     in   1      1 = write, 0 = read
//   cmd_addr   in   ADDR   target register
//   cmd_wdata  in   WIDTH  write data; ignored for reads
//   rsp_valid  out  1      read response present
//   rsp_ready  in   1      consumer accepts the response
//   rsp_addr   out  ADDR   address the response belongs to
//   rsp_rdata  out  WIDTH  read data
//   WrEn       out  1      to register file
//   RdEn       out  1      to register file
//   Address    out  ADDR   to register file
//   WrData     out  WIDTH  to register file
//   RdData     in   WIDTH  from register file
//   wr_count   out  8      completed writes, wraps 255->0
//   rd_count   out  8      completed read responses, wraps 255->0
// BEHAVIOUR
//   Reset (async): outputs, counters and latched registers go to 0; state goes to IDLE.
//     WrEn/RdEn fall immediately. cmd_ready=0 while rst=1.
//   FSM: IDLE, WR, RD, RD_WAIT, RSP. All pin outputs are registered except cmd_ready.
//   cmd_ready = (state==IDLE) & ~rst.
//     cmd_* are ignored when cmd_ready=0; a command held valid while busy is accepted once, in IDLE.
//   IDLE: on cmd_valid&cmd_ready, latch cmd_wr/cmd_addr/cmd_wdata.
//     Go to WR if cmd_wr=1, otherwise RD.
//   WR (1 cycle): WrEn=1 with the latched Address/WrData. wr_count+1. Next state IDLE.
//     Write latency: handshake in cycle N, WrEn high in N+1, cmd_ready high again in N+2.
//     Writes produce no response.
//   RD (1 cycle): RdEn=1 with the latched Address. Next state RD_WAIT; load wait counter with RD_LAT.
//   RD_WAIT: decrement the counter each cycle. On the cycle the counter reaches 1, register RdData
//     into rsp_rdata and the latched address into rsp_addr. Next state RSP.
//     Read latency: handshake in N, RdEn high in N+1, rsp_valid high in N+2+RD_LAT.
//   RSP: rsp_valid=1. rsp_addr/rsp_rdata stay stable until rsp_valid&rsp_ready.
//     On that handshake: rsp_valid=0, rd_count+1, next state IDLE.
//     A consumer that holds rsp_ready=1 sees rsp_valid for exactly 1 cycle.
//   WrEn and RdEn are never high together, and each is high for exactly 1 cycle per command.
//   Address/WrData keep their last values while both enables are low.
//   Counters wrap modulo 256 with no saturation and no flag.
//   Reset mid-operation: the in-flight command is dropped. No WrEn/RdEn pulse and no response
//     is produced for it after rst deasserts.
// TESTING
//   1. Write 0x000B->3, 0x0001->7, 0x001C->1, then read 3, 1, 7 -> rsp_rdata 0x000B, 0x001C, 0x0001
//      with matching rsp_addr; wr_count=3, rd_count=3.
//   2. Read 5 with rsp_ready=0 for 6 cycles -> rsp_valid and rsp_rdata stay stable, cmd_ready=0
//      throughout. Raise rsp_ready -> one handshake, then cmd_ready=1 the next cycle.
//   3. Back-to-back writes with cmd_valid held high -> one accepted every 2 cycles,
//      WrEn pulses 1 cycle each, no RdEn.
//   4. Assert rst during RD_WAIT -> RdEn/rsp_valid=0 at once, counters 0. After release,
//      no stray response appears; a new read returns the correct data.
//   5. 256 writes then 1 more -> wr_count reads 0 and then 1; the register-file contents are correct.
//   6. RD_LAT=3 build, read 2 -> rsp_valid rises exactly 5 cycles after the accept cycle.

Source files
------------

// File: rtl/reg_file_ctrl.sv
// rtl/reg_file_ctrl.sv - command sequencer driving an 8 x 16 register file's pin-level interface
module reg_file_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR   = $clog2(DEPTH),
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [ADDR-1:0]  cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ADDR-1:0]  rsp_addr,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             WrEn,
    output logic             RdEn,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    input  logic [WIDTH-1:0] RdData,
    output logic [7:0]       wr_count,
    output logic [7:0]       rd_count
);

    localparam int WAIT_W = 3;

    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RSP} state_t;

    state_t             state_q, state_d;
    logic               wr_en_q, wr_en_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ADDR-1:0]    rsp_addr_q, rsp_addr_d;
    logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [7:0]         wr_count_q, wr_count_d;
    logic [7:0]         rd_count_q, rd_count_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    // Only the accept signal is combinational, so a reset pulse blocks new commands at once.
    assign cmd_ready = (state_q == IDLE) & ~rst;

    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_rdata_d = rsp_rdata_q;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        wait_d      = wait_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d = cmd_addr;
                    if (cmd_wr) begin
                        wdata_d = cmd_wdata;
                        wr_en_d = 1'b1;
                        state_d = WR;
                    end else begin
                        rd_en_d = 1'b1;
                        state_d = RD;
                    end
                end
            end
            WR: begin
                wr_count_d = wr_count_q + 8'd1;
                state_d    = IDLE;
            end
            RD: begin
                wait_d  = WAIT_W'(RD_LAT);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // Count 1 marks the cycle in which the file's RdData is valid.
                if (wait_q == WAIT_W'(1)) begin
                    rsp_rdata_d = RdData;
                    rsp_addr_d  = addr_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rd_count_d  = rd_count_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
            wr_count_q  <= 8'd0;
            rd_count_q  <= 8'd0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            wait_q      <= wait_d;
        end
    end

    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign Address   = addr_q;
    assign WrData    = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign wr_count  = wr_count_q;
    assign rd_count  = rd_count_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb/tb_reg_file_ctrl.sv - directed bench for reg_file_ctrl with behavioural register-file models
module tb_reg_file_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        cmd_valid = 1'b0, cmd_wr = 1'b0, rsp_ready = 1'b0;
    logic [2:0]  cmd_addr = 3'd0;
    logic [15:0] cmd_wdata = 16'd0;
    logic        cmd_ready, rsp_valid, WrEn, RdEn;
    logic [2:0]  rsp_addr, Address;
    logic [15:0] rsp_rdata, WrData, RdData;
    logic [7:0]  wr_count, rd_count;

    logic        b_cmd_valid = 1'b0, b_rsp_ready = 1'b1;
    logic        b_cmd_ready, b_rsp_valid, b_WrEn, b_RdEn;
    logic [2:0]  b_rsp_addr, b_Address;
    logic [15:0] b_rsp_rdata, b_WrData, b_RdData;
    logic [7:0]  b_wr_count, b_rd_count;

    logic [15:0] mem_a [8];
    logic [15:0] mem_b [8];
    logic [15:0] pb0, pb1, pb2;

    int checks = 0;
    int errors = 0;
    int exp_wr = 0;

    always #5 clk = ~clk;

    reg_file_ctrl #(.RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData), .RdData(RdData),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    reg_file_ctrl #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_wr(1'b0),
        .cmd_addr(3'd2), .cmd_wdata(16'd0),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_addr(b_rsp_addr), .rsp_rdata(b_rsp_rdata),
        .WrEn(b_WrEn), .RdEn(b_RdEn), .Address(b_Address), .WrData(b_WrData), .RdData(b_RdData),
        .wr_count(b_wr_count), .rd_count(b_rd_count)
    );

    // Register file with 1-cycle read latency; data only presented in the cycle after RdEn.
    always @(posedge clk) begin
        if (WrEn) mem_a[Address] <= WrData;
        RdData <= RdEn ? mem_a[Address] : 16'hDEAD;
    end

    // Register file with 3-cycle read latency, preloaded contents.
    initial for (int i = 0; i < 8; i++) mem_b[i] = 16'h0100 + 16'(i);
    always @(posedge clk) begin
        if (b_WrEn) mem_b[b_Address] <= b_WrData;
        pb0 <= b_RdEn ? mem_b[b_Address] : 16'hDEAD;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign b_RdData = pb2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (!rst) chk("wr_rd_exclusive", 32'(WrEn & RdEn), 32'd0);

    task automatic send(input logic wr, input logic [2:0] a, input logic [15:0] d);
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("cmd_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        if (wr) exp_wr = (exp_wr + 1) % 256;
    endtask

    task automatic get_rsp(input string tag, input logic [2:0] a, input logic [15:0] d);
        bit ok = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
        chk({tag, "_addr"}, 32'(rsp_addr), 32'(a));
        chk({tag, "_data"}, 32'(rsp_rdata), 32'(d));
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_en", 32'({WrEn, RdEn, rsp_valid}), 32'd0);
        chk("rst_counts", 32'({wr_count, rd_count}), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Basic writes then reads
        send(1'b1, 3'd3, 16'h000B);
        send(1'b1, 3'd7, 16'h0001);
        send(1'b1, 3'd1, 16'h001C);
        send(1'b0, 3'd3, 16'h0); get_rsp("rd3", 3'd3, 16'h000B);
        send(1'b0, 3'd1, 16'h0); get_rsp("rd1", 3'd1, 16'h001C);
        send(1'b0, 3'd7, 16'h0); get_rsp("rd7", 3'd7, 16'h0001);
        @(negedge clk);
        chk("t1_wr_count", 32'(wr_count), 32'd3);
        chk("t1_rd_count", 32'(rd_count), 32'd3);

        // Response back-pressure
        send(1'b1, 3'd5, 16'h5A5A);
        send(1'b0, 3'd5, 16'h0);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", 32'(rsp_rdata), 32'h5A5A);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);
        chk("bp_rd_count", 32'(rd_count), 32'd4);

        // Back-to-back writes with cmd_valid held
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 3'd6; cmd_wdata = 16'h0600;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_cmd_ready", 32'(cmd_ready), 32'(i % 2));
            chk("b2b_wren", 32'(WrEn), 32'((i + 1) % 2));
            chk("b2b_rden", 32'(RdEn), 32'd0);
        end
        cmd_valid = 1'b0;
        exp_wr = exp_wr + 4;
        chk("b2b_wr_count", 32'(wr_count), 32'(exp_wr));

        // Reset during RD_WAIT
        send(1'b0, 3'd3, 16'h0);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("mid_rst_rden", 32'(RdEn), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_counts", 32'({wr_count, rd_count}), 32'd0);
        exp_wr = 0;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({rsp_valid, RdEn, WrEn}), 32'd0);
        end
        rsp_ready = 1'b0;
        send(1'b0, 3'd1, 16'h0); get_rsp("post_rst_rd1", 3'd1, 16'h001C);

        // Counter wrap
        for (int i = 0; i < 256; i++) send(1'b1, 3'(i), 16'(i));
        @(posedge clk); #1;
        chk("wrap_wr_count0", 32'(wr_count), 32'd0);
        send(1'b1, 3'd0, 16'hBEEF);
        @(posedge clk); #1;
        chk("wrap_wr_count1", 32'(wr_count), 32'd1);
        send(1'b0, 3'd0, 16'h0); get_rsp("wrap_rd0", 3'd0, 16'hBEEF);
        send(1'b0, 3'd5, 16'h0); get_rsp("wrap_rd5", 3'd5, 16'h00FD);

        // RD_LAT=3 instance: rsp_valid five cycles after accept
        @(negedge clk);
        chk("lat3_cmd_ready", 32'(b_cmd_ready), 32'd1);
        b_cmd_valid = 1'b1;
        @(posedge clk); #1 b_cmd_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("lat3_rsp_valid", 32'(b_rsp_valid), 32'(k == 5));
            if (k == 5) begin
                chk("lat3_rsp_data", 32'(b_rsp_rdata), 32'h0102);
                chk("lat3_rsp_addr", 32'(b_rsp_addr), 32'd2);
            end
        end
        chk("lat3_rd_count", 32'(b_rd_count), 32'd1);
        chk("lat3_no_wren", 32'(b_WrEn), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
